// File: rtl/if_fetch_ctrl.sv
// Fetch controller for the IF stage: owns the PC, drives a req/ready
// instruction memory and produces load/freeze/flush for the IF register.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_freeze,
    output logic        if_flush,
    output logic        fetch_timeout
);

    typedef enum logic [1:0] {S_BOOT, S_REQ, S_STALL, S_DRAIN} state_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_old_addr;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic [3:0]  r_wait_cnt;
    logic        r_timeout;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_old_nxt;
    logic [31:0] w_buf_instr_nxt;
    logic [31:0] w_buf_pc_nxt;
    logic [3:0]  w_wait_nxt;
    logic [31:0] w_pc_inc;

    assign w_pc_inc      = r_pc + 32'd4;
    assign fetch_timeout = r_timeout;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_old_nxt       = r_old_addr;
        w_buf_instr_nxt = r_buf_instr;
        w_buf_pc_nxt    = r_buf_pc;
        imem_req        = 1'b0;
        imem_addr       = r_pc;
        if_pc           = 32'd0;
        if_instr        = 32'd0;
        if_freeze       = 1'b0;
        if_flush        = 1'b0;
        case (r_state)
            S_BOOT: begin
                if_flush    = 1'b1;
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    if_flush        = 1'b1;
                    w_pc_nxt        = branch_addr;
                    w_buf_instr_nxt = 32'd0;
                    w_buf_pc_nxt    = 32'd0;
                    // Pending request must finish at its original address
                    if (imem_ready) w_state_nxt = S_REQ;
                    else begin
                        w_state_nxt = S_DRAIN;
                        w_old_nxt   = r_pc;
                    end
                end else if (imem_ready) begin
                    w_pc_nxt = w_pc_inc;
                    if (hazard_freeze) begin
                        if_freeze       = 1'b1;
                        w_buf_instr_nxt = imem_rdata;
                        w_buf_pc_nxt    = w_pc_inc;
                        w_state_nxt     = S_STALL;
                    end else begin
                        if_pc    = w_pc_inc;
                        if_instr = imem_rdata;
                    end
                end else if (hazard_freeze) begin
                    if_freeze = 1'b1;
                end else begin
                    if_flush = 1'b1;
                end
            end
            S_STALL: begin
                if (branch_taken) begin
                    if_flush        = 1'b1;
                    w_pc_nxt        = branch_addr;
                    w_buf_instr_nxt = 32'd0;
                    w_buf_pc_nxt    = 32'd0;
                    w_state_nxt     = S_REQ;
                end else if (hazard_freeze) begin
                    if_freeze = 1'b1;
                end else begin
                    if_pc       = r_buf_pc;
                    if_instr    = r_buf_instr;
                    w_state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = r_old_addr;
                if (branch_taken) begin
                    if_flush        = 1'b1;
                    w_pc_nxt        = branch_addr;
                    w_buf_instr_nxt = 32'd0;
                    w_buf_pc_nxt    = 32'd0;
                end else if (hazard_freeze) begin
                    if_freeze = 1'b1;
                end else begin
                    if_flush = 1'b1;
                end
                if (imem_ready) w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (!imem_req || imem_ready) w_wait_nxt = 4'd0;
        else if (r_wait_cnt != 4'hF) w_wait_nxt = r_wait_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_PC;
            r_old_addr  <= RESET_PC;
            r_buf_instr <= 32'd0;
            r_buf_pc    <= 32'd0;
            r_wait_cnt  <= 4'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_old_addr  <= w_old_nxt;
            r_buf_instr <= w_buf_instr_nxt;
            r_buf_pc    <= w_buf_pc_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_timeout   <= r_timeout | (w_wait_nxt == MAX_W);
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: boot, streaming, wait states, freeze,
// branch redirect during a pending fetch, PC wrap and the sticky timeout.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        hazard_freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_freeze;
    logic        if_flush;
    logic        fetch_timeout;

    int n_cmp = 0;
    int n_err = 0;

    if_fetch_ctrl #(.RESET_PC(32'h0), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst),
        .hazard_freeze(hazard_freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_pc(if_pc), .if_instr(if_instr),
        .if_freeze(if_freeze), .if_flush(if_flush),
        .fetch_timeout(fetch_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the edge; outputs are sampled 1ns later.
    task automatic drive(input logic hf, input logic bt, input logic [31:0] ba,
                         input logic rdy, input logic [31:0] rd);
        hazard_freeze = hf;
        branch_taken  = bt;
        branch_addr   = ba;
        imem_ready    = rdy;
        imem_rdata    = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic req, input logic frz, input logic fl);
        chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
        chk({tag, ".freeze"}, {31'd0, if_freeze}, {31'd0, frz});
        chk({tag, ".flush"}, {31'd0, if_flush}, {31'd0, fl});
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        tick();
        // reset held: BOOT outputs
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'd0);
        chk_ctl("rst", 1'b0, 1'b0, 1'b1);
        chk("rst.addr", imem_addr, 32'h0);
        chk("rst.if_pc", if_pc, 32'h0);
        chk("rst.timeout", {31'd0, fetch_timeout}, 32'd0);

        // release: one BOOT cycle, then single-cycle memory
        rst = 1'b1;
        #1;
        chk_ctl("boot", 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hAAAA_0000);
        chk_ctl("s0", 1'b1, 1'b0, 1'b0);
        chk("s0.addr", imem_addr, 32'h0);
        chk("s0.if_pc", if_pc, 32'h4);
        chk("s0.instr", if_instr, 32'hAAAA_0000);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hAAAA_0004);
        chk("s1.addr", imem_addr, 32'h4);
        chk("s1.if_pc", if_pc, 32'h8);
        chk("s1.instr", if_instr, 32'hAAAA_0004);
        tick();

        // freeze arrives with ready at pc=8
        drive(1'b1, 1'b0, 32'd0, 1'b1, 32'hBBBB_0008);
        chk_ctl("fz0", 1'b1, 1'b1, 1'b0);
        chk("fz0.addr", imem_addr, 32'h8);
        tick();
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
            chk_ctl($sformatf("fz%0d", i), 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk_ctl("rel", 1'b0, 1'b0, 1'b0);
        chk("rel.if_pc", if_pc, 32'hC);
        chk("rel.instr", if_instr, 32'hBBBB_0008);
        tick();

        // ready every third cycle at pc=12
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk_ctl("w0", 1'b1, 1'b0, 1'b1);
        chk("w0.addr", imem_addr, 32'hC);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk_ctl("w1", 1'b1, 1'b0, 1'b1);
        chk("w1.addr", imem_addr, 32'hC);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hCCCC_000C);
        chk_ctl("w2", 1'b1, 1'b0, 1'b0);
        chk("w2.addr", imem_addr, 32'hC);
        chk("w2.if_pc", if_pc, 32'h10);
        chk("w2.instr", if_instr, 32'hCCCC_000C);
        tick();

        // branch to 0x100 while fetch at 0x10 still pending
        drive(1'b0, 1'b1, 32'h100, 1'b0, 32'd0);
        chk_ctl("br0", 1'b1, 1'b0, 1'b1);
        chk("br0.addr", imem_addr, 32'h10);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk_ctl("dr0", 1'b1, 1'b0, 1'b1);
        chk("dr0.addr", imem_addr, 32'h10);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hDEAD_DEAD);
        chk_ctl("dr1", 1'b1, 1'b0, 1'b1);
        chk("dr1.addr", imem_addr, 32'h10);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hDDDD_0100);
        chk("tgt.addr", imem_addr, 32'h100);
        chk("tgt.if_pc", if_pc, 32'h104);
        chk("tgt.instr", if_instr, 32'hDDDD_0100);
        tick();

        // branch and freeze together in STALL
        drive(1'b1, 1'b0, 32'd0, 1'b1, 32'hEEEE_0104);
        tick();
        drive(1'b1, 1'b1, 32'h200, 1'b0, 32'd0);
        chk_ctl("sbr", 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_0200);
        chk("sbr.addr", imem_addr, 32'h200);
        chk("sbr.if_pc", if_pc, 32'h204);
        chk("sbr.instr", if_instr, 32'hFFFF_0200);
        tick();

        // PC wrap at the top of the address space
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'd0);
        chk_ctl("wr0", 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h1111_1111);
        chk("wr.addr", imem_addr, 32'hFFFF_FFFC);
        chk("wr.if_pc", if_pc, 32'h0);
        tick();

        // long wait at pc=0: timeout on the 15th wait cycle, sticky afterward
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < 14; i++) tick();
        chk("to14", {31'd0, fetch_timeout}, 32'd0);
        chk("to14.addr", imem_addr, 32'h0);
        tick();
        chk("to15", {31'd0, fetch_timeout}, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h2222_0000);
        chk("to.if_pc", if_pc, 32'h4);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("to.sticky", {31'd0, fetch_timeout}, 32'd1);
        chk("to.addr", imem_addr, 32'h4);
        tick();
        tick();

        // reset mid-wait drops the request and clears the timeout
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk_ctl("rst2", 1'b0, 1'b0, 1'b1);
        chk("rst2.timeout", {31'd0, fetch_timeout}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("rst2.addr", imem_addr, 32'h0);
        chk_ctl("rst2.req", 1'b1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Fetch controller that sequences the IF pipeline register. It owns the PC and drives a variable-latency instruction memory through a req/ready handshake. It generates the load/freeze and flush controls for the IF stage register, and arbitrates between memory wait states, hazard freezes and taken-branch redirects. It sits between the instruction memory, the hazard unit and the EX-stage branch logic, feeding pc/instruction/freeze/flush to the IF stage register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 15, wait cycles without imem_ready before fetch_timeout sets (4-bit counter range, 1..15)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-low reset
hazard_freeze  in  1  hazard unit requests IF hold
branch_taken  in  1  taken branch/redirect this cycle
branch_addr  in  32  redirect target
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (current PC)
imem_ready  in  1  memory returns data this cycle
imem_rdata  in  32  fetched instruction
if_pc  out  32  PC+4 of delivered instruction (IF register pcin)
if_instr  out  32  delivered instruction (IF register instructionin)
if_freeze  out  1  IF register hold (load = ~if_freeze)
if_flush  out  1  IF register clear (bubble insert)
fetch_timeout  out  1  sticky: a request waited MAX_WAIT cycles

Behaviour:
- Registered state: pc, FSM state, skid buffer (32b instruction + 32b pc+4), 4-bit wait_cnt, fetch_timeout. if_* and imem_* outputs are combinational from state plus inputs.
- rst=0 at a clock edge: pc=RESET_PC, state=BOOT, buffer=0, wait_cnt=0, fetch_timeout=0. Applies mid-request as well: the outstanding request is abandoned without waiting for ready.
- BOOT outputs: imem_req=0, imem_addr=pc, if_flush=1, if_freeze=0, if_pc=0, if_instr=0. Next state is always REQ.
- REQ: imem_req=1, imem_addr=pc.
  - ready=1, no freeze, no branch: if_pc=pc+4, if_instr=imem_rdata, if_freeze=0, if_flush=0; pc<=pc+4; stay in REQ. Zero added latency, one instruction per cycle.
  - ready=1 with hazard_freeze=1: capture rdata and pc+4 into the buffer; pc<=pc+4; if_freeze=1; go to STALL.
  - ready=0 with hazard_freeze=0: if_flush=1 (bubble), if_freeze=0.
  - ready=0 with hazard_freeze=1: if_freeze=1, if_flush=0.
- STALL: imem_req=0; if_freeze=1 while hazard_freeze=1. When hazard_freeze drops, present the buffer on if_pc/if_instr with if_freeze=0, then go to REQ next cycle.
- DRAIN: imem_req=1 with the OLD address held. On ready, discard the data and go to REQ using the already-redirected pc. Output if_flush=1 unless hazard_freeze=1, in which case if_freeze=1.
- Handshake rule: once imem_req=1, imem_addr stays stable until a cycle with imem_ready=1. Only rst may drop an outstanding request.
- branch_taken=1 has priority over freeze and ready in every state except BOOT (BOOT ignores it):
  - Action: pc<=branch_addr, if_flush=1, if_freeze=0, buffer invalidated.
  - In REQ with ready=0, go to DRAIN, keeping the old addr for the pending request.
  - In REQ with ready=1, or in STALL/DRAIN-with-ready, go to REQ.
  - In DRAIN with ready=0, stay in DRAIN; pc takes the newest target.
- wait_cnt: cleared on ready and whenever imem_req=0; otherwise increments, saturating at 15. fetch_timeout sets when wait_cnt reaches MAX_WAIT and clears only on reset.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.

Test Plan:
- Reset then single-cycle memory (ready always 1, rdata=pc): BOOT flush for 1 cycle, then if_pc = 4, 8, 12… on consecutive cycles, if_freeze=0, if_flush=0.
- Memory ready every 3rd cycle, no freeze: fetch at pc=0 produces 2 bubbles (if_flush=1) then if_instr valid with if_pc=4. imem_addr stays 0 for all 3 cycles.
- Freeze held 4 cycles arriving with ready for pc=8: instruction buffered, if_freeze=1 for 4 cycles, no imem_req. On release, if_pc=12 with the buffered instruction; next fetch addr=12.
- branch_taken with branch_addr=0x100 while a fetch to 0x20 is pending (ready low 2 more cycles): addr stays 0x20 until ready, data discarded, if_flush=1 throughout. Next imem_addr=0x100 and delivered if_pc=0x104.
- branch_taken and hazard_freeze together in STALL: flush wins, buffer dropped, next fetch at branch_addr.
- ready held low 20 cycles with MAX_WAIT=15: fetch_timeout rises on the 15th wait cycle and stays 1 after ready returns. A rst=0 pulse mid-wait clears it, with imem_req=0 the next cycle.
